// File: rtl/lag_measure_pkg.sv
// Shared types for the display-lag measurement block: BCD value type,
// FSM state encoding, BCD limits and the bcdcount field offsets.
package lag_types;

  typedef logic [19:0] bcd5_t;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } lag_state_t;

  localparam bcd5_t BCD5_MAX  = 20'h99999;
  localparam bcd5_t BCD5_ZERO = 20'h00000;

  // Field offsets of the four statistics inside bcdcount
  localparam int LAST_LSB  = 60;
  localparam int MIN_LSB   = 40;
  localparam int MAX_LSB   = 20;
  localparam int COUNT_LSB = 0;

  localparam int PRESCALE_W = 12;

endpackage

// File: rtl/lag_measure_bcd5_inc.sv
// Combinational 5-digit packed-BCD incrementer with ripple per-digit carry.
// value_o wraps to 00000 from 99999; callers use at_max_o to saturate.
module bcd5_inc
  import lag_types::*;
(
  input  bcd5_t value_i,
  output bcd5_t value_o,
  output logic  at_max_o
);

  logic carry_s;

  // Add one to the least significant digit and ripple carries upward
  always_comb begin
    value_o = value_i;
    carry_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (carry_s) begin
        if (value_i[i*4 +: 4] >= 4'd9) begin
          value_o[i*4 +: 4] = 4'd0;
          carry_s           = 1'b1;
        end else begin
          value_o[i*4 +: 4] = value_i[i*4 +: 4] + 4'd1;
          carry_s           = 1'b0;
        end
      end else begin
        value_o[i*4 +: 4] = value_i[i*4 +: 4];
      end
    end
  end

  assign at_max_o = (value_i == BCD5_MAX);

endmodule

// File: rtl/lag_measure.sv
// Display-lag meter: counts 10 us ticks from starttrigger until the photo
// sensor fires and keeps last/min/max/count statistics in packed BCD.
// Optional macro LAG_SENSOR_DEBOUNCE_EN adds a consecutive-high debounce
// stage of DEBOUNCE_CYCLES cycles after the sensor synchroniser.
module lag_measure
  import lag_types::*;
#(
  parameter int TICK_DIV = 742
`ifdef LAG_SENSOR_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        starttrigger,
  input  logic        sensor,
  input  logic        clear_stats,
  output logic [79:0] bcdcount,
  output logic        measuring,
  output logic        timeout
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(TICK_DIV - 1);

  lag_state_t            state_q, state_d;
  bcd5_t                 acc_q, acc_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  bcd5_t                 last_q, last_d, min_q, min_d, max_q, max_d;
  bcd5_t                 count_q, count_d;
  logic                  timeout_q, timeout_d;
  logic                  measuring_q, measuring_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  sensor_det;
  bcd5_t                 acc_inc, count_inc;
  logic                  acc_at_max, count_at_max;

  bcd5_inc u_acc_inc (
    .value_i  (acc_q),
    .value_o  (acc_inc),
    .at_max_o (acc_at_max)
  );

  bcd5_inc u_count_inc (
    .value_i  (count_q),
    .value_o  (count_inc),
    .at_max_o (count_at_max)
  );

  // Two-flop synchroniser for the asynchronous sensor pin
  always_comb begin
    sync1_d = sensor;
    sync2_d = sync1_q;
  end

`ifdef LAG_SENSOR_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);

  logic [DB_W-1:0] deb_q, deb_d;

  // Count consecutive synced-high samples; any low sample restarts the count
  always_comb begin
    if (!sync2_q) begin
      deb_d = '0;
    end else if (deb_q == DB_FULL) begin
      deb_d = deb_q;
    end else begin
      deb_d = deb_q + 1'b1;
    end
  end

  // Debounce counter register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end

  // Detection drops as soon as the synced sample goes low
  assign sensor_det = sync2_q && (deb_q == DB_FULL);
`else
  assign sensor_det = sync2_q;
`endif

  // Measurement FSM, prescaler, accumulator and statistics update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pre_d     = pre_q;
    timeout_d = timeout_q;
    last_d    = last_q;
    min_d     = min_q;
    max_d     = max_q;
    count_d   = count_q;

    case (state_q)
      ARMED: begin
        if (starttrigger) begin
          state_d   = MEASURE;
          acc_d     = BCD5_ZERO;
          pre_d     = '0;
          timeout_d = 1'b0;
        end else begin
          state_d = ARMED;
        end
      end
      MEASURE: begin
        if (sensor_det) begin
          last_d  = acc_q;
          if (acc_q < min_q) begin
            min_d = acc_q;
          end else begin
            min_d = min_q;
          end
          if (acc_q > max_q) begin
            max_d = acc_q;
          end else begin
            max_d = max_q;
          end
          if (count_at_max) begin
            count_d = count_q;
          end else begin
            count_d = count_inc;
          end
          state_d = HOLD;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (acc_at_max) begin
            last_d    = BCD5_MAX;
            timeout_d = 1'b1;
            state_d   = HOLD;
          end else begin
            acc_d = acc_inc;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      HOLD: begin
        if (!sensor_det) begin
          state_d = ARMED;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase

    // Clearing the statistics overrides a coincident capture
    if (clear_stats) begin
      last_d  = BCD5_ZERO;
      min_d   = BCD5_MAX;
      max_d   = BCD5_ZERO;
      count_d = BCD5_ZERO;
    end else begin
      last_d = last_d;
    end

    measuring_d = (state_d == MEASURE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ARMED;
      acc_q       <= BCD5_ZERO;
      pre_q       <= '0;
      timeout_q   <= 1'b0;
      measuring_q <= 1'b0;
      last_q      <= BCD5_ZERO;
      min_q       <= BCD5_MAX;
      max_q       <= BCD5_ZERO;
      count_q     <= BCD5_ZERO;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pre_q       <= pre_d;
      timeout_q   <= timeout_d;
      measuring_q <= measuring_d;
      last_q      <= last_d;
      min_q       <= min_d;
      max_q       <= max_d;
      count_q     <= count_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

  assign bcdcount[LAST_LSB  +: 20] = last_q;
  assign bcdcount[MIN_LSB   +: 20] = min_q;
  assign bcdcount[MAX_LSB   +: 20] = max_q;
  assign bcdcount[COUNT_LSB +: 20] = count_q;
  assign measuring = measuring_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_lag_measure.sv
// Directed testbench for lag_measure, run with TICK_DIV=2 so a lag of N
// ticks takes 2*N clock cycles. Honours LAG_SENSOR_DEBOUNCE_EN.
module tb_lag_measure;
  import lag_types::*;

`ifdef LAG_SENSOR_DEBOUNCE_EN
  localparam int DEB = 16;
`else
  localparam int DEB = 0;
`endif
  localparam logic [79:0] RESET_PAT = 80'h00000_99999_00000_00000;

  logic        clock;
  logic        reset_n;
  logic        starttrigger;
  logic        sensor;
  logic        clear_stats;
  logic [79:0] bcdcount;
  logic        measuring;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  lag_measure #(.TICK_DIV(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .starttrigger (starttrigger),
    .sensor       (sensor),
    .clear_stats  (clear_stats),
    .bcdcount     (bcdcount),
    .measuring    (measuring),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Trigger, raise the sensor 2*n cycles later, optionally clear on the capture cycle
  task automatic measure(input int n, input bit clr, input bit mid_trig);
    starttrigger = 1'b1;
    @(negedge clock);
    starttrigger = 1'b0;
    for (int i = 0; i < 2*n - 1; i++) begin
      starttrigger = (mid_trig && i == n) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    starttrigger = 1'b0;
    sensor = 1'b1;
    repeat (2 + DEB) @(negedge clock);
    clear_stats = clr;
    @(negedge clock);
    clear_stats = 1'b0;
  endtask

  task automatic drop_sensor();
    sensor = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bcdcount !== RESET_PAT) begin
      errors++; $display("FAIL reset_bcd: got %h expected %h", bcdcount, RESET_PAT);
    end
    checks++;
    if (measuring !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got meas=%b to=%b expected 0 0", measuring, timeout);
    end
    checks++;
    if (dut.state_q !== ARMED) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ARMED);
    end
  endtask

  task automatic test_single();
    logic [19:0] exp_v;
    exp_v = to_bcd(12345 + DEB/2);
    measure(12345, 1'b0, 1'b0);
    checks++;
    if (bcdcount !== {exp_v, exp_v, exp_v, 20'h00001}) begin
      errors++; $display("FAIL single_stats: got %h expected %h", bcdcount, {exp_v, exp_v, exp_v, 20'h00001});
    end
    checks++;
    if (dut.state_q !== HOLD || measuring !== 1'b0) begin
      errors++; $display("FAIL single_hold: got state=%0d meas=%b expected %0d 0", dut.state_q, measuring, HOLD);
    end
    starttrigger = 1'b1;
    @(negedge clock);
    starttrigger = 1'b0;
    @(negedge clock);
    checks++;
    if (dut.state_q !== HOLD) begin
      errors++; $display("FAIL hold_ignores_trigger: got %0d expected %0d", dut.state_q, HOLD);
    end
    drop_sensor();
    checks++;
    if (dut.state_q !== ARMED) begin
      errors++; $display("FAIL hold_release: got %0d expected %0d", dut.state_q, ARMED);
    end
  endtask

  task automatic test_multi();
    logic [79:0] exp_b;
    do_reset();
    measure(500, 1'b0, 1'b0); drop_sensor();
    measure(200, 1'b0, 1'b0); drop_sensor();
    measure(900, 1'b0, 1'b1);
    exp_b = {to_bcd(900 + DEB/2), to_bcd(200 + DEB/2), to_bcd(900 + DEB/2), 20'h00003};
    checks++;
    if (bcdcount !== exp_b) begin
      errors++; $display("FAIL multi_stats: got %h expected %h", bcdcount, exp_b);
    end
    drop_sensor();
  endtask

  task automatic test_timeout();
    logic [79:0] exp_b;
    int cyc;
    exp_b = {20'h99999, to_bcd(200 + DEB/2), to_bcd(900 + DEB/2), 20'h00003};
    starttrigger = 1'b1;
    @(negedge clock);
    starttrigger = 1'b0;
    cyc = 0;
    while (timeout !== 1'b1 && cyc < 210000) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (cyc !== 200000) begin
      errors++; $display("FAIL timeout_cycles: got %0d expected 200000", cyc);
    end
    checks++;
    if (bcdcount !== exp_b) begin
      errors++; $display("FAIL timeout_stats: got %h expected %h", bcdcount, exp_b);
    end
    checks++;
    if (measuring !== 1'b0) begin
      errors++; $display("FAIL timeout_meas: got %b expected 0", measuring);
    end
    repeat (2) @(negedge clock);
    starttrigger = 1'b1;
    @(negedge clock);
    starttrigger = 1'b0;
    checks++;
    if (timeout !== 1'b0 || measuring !== 1'b1) begin
      errors++; $display("FAIL timeout_rearm: got to=%b meas=%b expected 0 1", timeout, measuring);
    end
    sensor = 1'b1;
    repeat (3 + DEB) @(negedge clock);
    checks++;
    if (bcdcount[19:0] !== 20'h00004 || measuring !== 1'b0) begin
      errors++; $display("FAIL rearm_capture: got cnt=%h meas=%b expected 00004 0", bcdcount[19:0], measuring);
    end
    drop_sensor();
  endtask

  task automatic test_clear_capture();
    measure(7, 1'b1, 1'b0);
    checks++;
    if (bcdcount !== RESET_PAT) begin
      errors++; $display("FAIL clear_vs_capture: got %h expected %h", bcdcount, RESET_PAT);
    end
    checks++;
    if (dut.state_q !== HOLD) begin
      errors++; $display("FAIL clear_state: got %0d expected %0d", dut.state_q, HOLD);
    end
    drop_sensor();
  endtask

  task automatic test_zero_lag();
    sensor = 1'b1;
    repeat (3 + DEB) @(negedge clock);
    checks++;
    if (dut.state_q !== ARMED) begin
      errors++; $display("FAIL zero_armed: got %0d expected %0d", dut.state_q, ARMED);
    end
    starttrigger = 1'b1;
    @(negedge clock);
    starttrigger = 1'b0;
    checks++;
    if (measuring !== 1'b1) begin
      errors++; $display("FAIL zero_trigger_cycle: got %b expected 1", measuring);
    end
    @(negedge clock);
    checks++;
    if (bcdcount !== 80'h00000_00000_00000_00001 || measuring !== 1'b0) begin
      errors++; $display("FAIL zero_capture: got %h meas=%b expected 00000000000000000001 0", bcdcount, measuring);
    end
    drop_sensor();
  endtask

  task automatic test_reset_mid();
    starttrigger = 1'b1;
    @(negedge clock);
    starttrigger = 1'b0;
    repeat (50) @(negedge clock);
    checks++;
    if (measuring !== 1'b1) begin
      errors++; $display("FAIL mid_measuring: got %b expected 1", measuring);
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checks++;
    if (bcdcount !== RESET_PAT || measuring !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got %h meas=%b to=%b expected %h 0 0", bcdcount, measuring, timeout, RESET_PAT);
    end
    checks++;
    if (dut.state_q !== ARMED || dut.acc_q !== 20'h00000) begin
      errors++; $display("FAIL mid_reset_state: got st=%0d acc=%h expected %0d 00000", dut.state_q, dut.acc_q, ARMED);
    end
  endtask

`ifdef LAG_SENSOR_DEBOUNCE_EN
  task automatic test_debounce();
    int k;
    starttrigger = 1'b1;
    @(negedge clock);
    starttrigger = 1'b0;
    repeat (5) @(negedge clock);
    sensor = 1'b1;
    repeat (10) @(negedge clock);
    sensor = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if (measuring !== 1'b1) begin
      errors++; $display("FAIL glitch_ignored: got %b expected 1", measuring);
    end
    sensor = 1'b1;
    k = 0;
    while (measuring === 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (k !== 19) begin
      errors++; $display("FAIL debounce_latency: got %0d expected 19", k);
    end
    drop_sensor();
  endtask
`endif

  initial begin
    reset_n      = 1'b0;
    starttrigger = 1'b0;
    sensor       = 1'b0;
    clear_stats  = 1'b0;
    @(negedge clock);
    test_reset();
    test_single();
    test_multi();
    test_timeout();
    test_clear_capture();
    test_zero_lag();
    test_reset_mid();
`ifdef LAG_SENSOR_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
